// File: rtl/rf_write_arbiter_if.sv
// Bundle of issue, ALU writeback, long-unit result, register-file write port and scoreboard
// signals for rf_write_arbiter.
interface rf_write_arbiter_if;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;

    logic              iss_valid;
    logic              iss_long;
    logic [REG_W-1:0]  iss_rd;
    logic [REG_W-1:0]  iss_rs1;
    logic [REG_W-1:0]  iss_rs2;
    logic              stall;

    logic              alu_wr;
    logic [REG_W-1:0]  alu_rd;
    logic [DATA_W-1:0] alu_wdata;

    logic              lu_valid;
    logic              lu_ready;
    logic [REG_W-1:0]  lu_rd;
    logic [DATA_W-1:0] lu_wdata;

    logic              rf_wr;
    logic [REG_W-1:0]  rf_rd;
    logic [DATA_W-1:0] rf_wdata;

    logic [NREG-1:0]   busy_vec;

    // Environment side: issue stage, ALU and long unit
    modport master (
        output iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2,
        output alu_wr, alu_rd, alu_wdata,
        output lu_valid, lu_rd, lu_wdata,
        input  stall, lu_ready, rf_wr, rf_rd, rf_wdata, busy_vec
    );

    // Arbiter side
    modport slave (
        input  iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2,
        input  alu_wr, alu_rd, alu_wdata,
        input  lu_valid, lu_rd, lu_wdata,
        output stall, lu_ready, rf_wr, rf_rd, rf_wdata, busy_vec
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port between the ALU (priority) and a 2-deep long-unit result
// FIFO, tracks outstanding long results in a scoreboard, and stalls issue on hazards or starvation.
module rf_write_arbiter #(
    parameter int unsigned AGE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned AGE_CW = $clog2(AGE_MAX + 1);
    localparam int unsigned AGE_W  = (AGE_CW < 2) ? 2 : AGE_CW;
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

    logic [REG_W-1:0]  ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [AGE_W-1:0]  age;
    logic [NREG-1:0]   busy;

    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [REG_W-1:0]  head_rd;
    logic [DATA_W-1:0] head_data;
    logic              hazard;
    logic              stall_int;
    logic              busy_set;
    logic [NREG-1:0]   busy_nxt;
    logic [AGE_W-1:0]  age_nxt;
    logic [1:0]        count_nxt;

    assign fifo_empty = (count == 2'd0);
    assign fifo_full  = (count == 2'(DEPTH));
    assign push       = bus.lu_valid & ~fifo_full;
    assign pop        = ~bus.alu_wr & ~fifo_empty;
    assign head_rd    = ent_rd[rd_ptr];
    assign head_data  = ent_data[rd_ptr];

    assign bus.lu_ready = ~fifo_full;
    assign bus.busy_vec = busy;

    // Write port: ALU wins, otherwise drain the FIFO head
    always_comb begin
        bus.rf_wr    = 1'b0;
        bus.rf_rd    = '0;
        bus.rf_wdata = '0;
        if (bus.alu_wr) begin
            bus.rf_wr    = 1'b1;
            bus.rf_rd    = bus.alu_rd;
            bus.rf_wdata = bus.alu_wdata;
        end else if (!fifo_empty) begin
            bus.rf_wr    = 1'b1;
            bus.rf_rd    = head_rd;
            bus.rf_wdata = head_data;
        end
    end

    // RAW/WAW hazard on the scoreboard, or a starved FIFO head forcing an issue bubble
    assign hazard    = busy[bus.iss_rs1] | busy[bus.iss_rs2] | busy[bus.iss_rd];
    assign stall_int = (bus.iss_valid & hazard) | (age == AGE_SAT);
    assign bus.stall = stall_int;
    assign busy_set  = bus.iss_valid & bus.iss_long & ~stall_int & (bus.iss_rd != '0);

    always_comb begin
        busy_nxt = busy;
        if (pop)      busy_nxt[head_rd]    = 1'b0;
        if (busy_set) busy_nxt[bus.iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        age_nxt = age;
        if (fifo_empty || pop)                age_nxt = '0;
        else if (bus.alu_wr && age != AGE_SAT) age_nxt = age + AGE_W'(1);
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            age    <= '0;
            busy   <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count_nxt;
            age   <= age_nxt;
            busy  <= busy_nxt;
        end
    end

    // FIFO storage; reset clears it so no stale entry survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_rd[i]   <= '0;
                ent_data[i] <= '0;
            end
        end else if (push) begin
            ent_rd[wr_ptr]   <= bus.lu_rd;
            ent_data[wr_ptr] <= bus.lu_wdata;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a scoreboard queue holds expected register-file writes
// that a negedge monitor checks; scoreboard/handshake/stall values are checked inline.
module tb_rf_write_arbiter;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    wr_t  exp_q[$];

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.AGE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs settle 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic exp_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic idle_inputs();
        bus.iss_valid = 1'b0;
        bus.iss_long  = 1'b0;
        bus.iss_rd    = '0;
        bus.iss_rs1   = '0;
        bus.iss_rs2   = '0;
        bus.alu_wr    = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_wdata = '0;
        bus.lu_valid  = 1'b0;
        bus.lu_rd     = '0;
        bus.lu_wdata  = '0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        bus.iss_valid = 1'b1;
        bus.iss_long  = 1'b1;
        bus.iss_rd    = rd;
        bus.iss_rs1   = '0;
        bus.iss_rs2   = '0;
        step();
        bus.iss_valid = 1'b0;
        bus.iss_long  = 1'b0;
    endtask

    task automatic alu(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.alu_wr    = en;
        bus.alu_rd    = rd;
        bus.alu_wdata = data;
        if (en) exp_wr(rd, data);
    endtask

    task automatic lu(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.lu_valid = en;
        bus.lu_rd    = rd;
        bus.lu_wdata = data;
    endtask

    // Monitor: every register-file write must match the oldest expected write
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (bus.rf_wr === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rf_write_unexpected: got rd=%0d data=0x%08h with nothing expected at %0t",
                             bus.rf_rd, bus.rf_wdata, $time);
                end else begin
                    w = exp_q.pop_front();
                    if (bus.rf_rd === w.rd && bus.rf_wdata === w.data) n_pass++;
                    else $display("FAIL rf_write: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h at %0t",
                                  bus.rf_rd, bus.rf_wdata, w.rd, w.data, $time);
                end
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("reset_busy", bus.busy_vec, 32'h0);
        chk("reset_lu_ready", 32'(bus.lu_ready), 32'h1);
        chk("reset_stall", 32'(bus.stall), 32'h0);
        chk("reset_rf_wr", 32'(bus.rf_wr), 32'h0);
        rst = 1'b0;
        step();

        // Long issue to x5, result returns, written one cycle after handshake
        bus.iss_valid = 1'b1; bus.iss_long = 1'b1; bus.iss_rd = 5'd5;
        bus.iss_rs1 = 5'd1; bus.iss_rs2 = 5'd2;
        settle();
        chk("issue_x5_stall", 32'(bus.stall), 32'h0);
        step();
        bus.iss_valid = 1'b0; bus.iss_long = 1'b0;
        settle();
        chk("busy_x5_set", bus.busy_vec, 32'h0000_0020);
        lu(1'b1, 5'd5, 32'hDEAD_BEEF);
        exp_wr(5'd5, 32'hDEAD_BEEF);
        step();
        lu(1'b0, '0, '0);
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd5;
        settle();
        chk("raw_rs2_stall", 32'(bus.stall), 32'h1);
        chk("x5_rf_wr_now", 32'(bus.rf_wr), 32'h1);
        step();
        settle();
        chk("busy_x5_clear", bus.busy_vec, 32'h0);
        chk("raw_released", 32'(bus.stall), 32'h0);
        bus.iss_long = 1'b1; bus.iss_rs2 = 5'd0;
        settle();
        chk("x0_never_stalls", 32'(bus.stall), 32'h0);
        step();
        bus.iss_valid = 1'b0; bus.iss_long = 1'b0;
        settle();
        chk("x0_never_busy", bus.busy_vec, 32'h0);

        // Two results starved by continuous ALU writes: fill, age saturation, drain
        issue_long(5'd6);
        issue_long(5'd8);
        settle();
        chk("busy_6_8", bus.busy_vec, 32'h0000_0140);
        alu(1'b1, 5'd1, 32'h0000_0101);
        lu(1'b1, 5'd6, 32'h0000_0066);
        step();
        alu(1'b1, 5'd2, 32'h0000_0102);
        lu(1'b1, 5'd8, 32'h0000_0088);
        settle();
        chk("ready_one_held", 32'(bus.lu_ready), 32'h1);
        step();
        lu(1'b0, '0, '0);
        alu(1'b1, 5'd3, 32'h0000_0103);
        settle();
        chk("ready_full", 32'(bus.lu_ready), 32'h0);
        chk("age1_no_stall", 32'(bus.stall), 32'h0);
        step();
        alu(1'b1, 5'd4, 32'h0000_0104);
        settle();
        chk("age2_no_stall", 32'(bus.stall), 32'h0);
        step();
        alu(1'b1, 5'd1, 32'h0000_0105);
        settle();
        chk("age3_stall", 32'(bus.stall), 32'h1);
        step();
        alu(1'b1, 5'd2, 32'h0000_0106);
        settle();
        chk("age_saturated_stall", 32'(bus.stall), 32'h1);
        step();
        alu(1'b0, '0, '0);
        exp_wr(5'd6, 32'h0000_0066);
        settle();
        chk("age_still_max", 32'(bus.stall), 32'h1);
        step();
        exp_wr(5'd8, 32'h0000_0088);
        settle();
        chk("age_cleared_on_pop", 32'(bus.stall), 32'h0);
        chk("busy_after_x6", bus.busy_vec, 32'h0000_0100);
        chk("ready_after_pop", 32'(bus.lu_ready), 32'h1);
        step();
        settle();
        chk("busy_drained", bus.busy_vec, 32'h0);

        // ALU write collides with FIFO head x9
        issue_long(5'd9);
        lu(1'b1, 5'd9, 32'h0000_0099);
        settle();
        chk("empty_fifo_no_write", 32'(bus.rf_wr), 32'h0);
        step();
        lu(1'b0, '0, '0);
        alu(1'b1, 5'd7, 32'h0000_0011);
        settle();
        chk("busy_x9_held", bus.busy_vec, 32'h0000_0200);
        step();
        alu(1'b0, '0, '0);
        exp_wr(5'd9, 32'h0000_0099);
        settle();
        chk("busy_x9_until_write", bus.busy_vec, 32'h0000_0200);
        step();
        settle();
        chk("busy_x9_clear", bus.busy_vec, 32'h0);

        // Simultaneous pop and push keep occupancy at one, order preserved
        issue_long(5'd10);
        issue_long(5'd11);
        lu(1'b1, 5'd10, 32'h0000_000A);
        step();
        lu(1'b1, 5'd11, 32'h0000_000B);
        exp_wr(5'd10, 32'h0000_000A);
        settle();
        chk("pushpop_ready", 32'(bus.lu_ready), 32'h1);
        step();
        lu(1'b0, '0, '0);
        exp_wr(5'd11, 32'h0000_000B);
        settle();
        chk("occupancy_one", 32'(bus.lu_ready), 32'h1);
        chk("occupancy_one_wr", 32'(bus.rf_wr), 32'h1);
        step();
        settle();
        chk("busy_10_11_clear", bus.busy_vec, 32'h0);

        // Reset mid-operation with two entries queued
        issue_long(5'd5);
        issue_long(5'd9);
        alu(1'b1, 5'd1, 32'h0000_0201);
        lu(1'b1, 5'd5, 32'h0000_0001);
        step();
        alu(1'b1, 5'd2, 32'h0000_0202);
        lu(1'b1, 5'd9, 32'h0000_0002);
        step();
        lu(1'b0, '0, '0);
        alu(1'b1, 5'd3, 32'h0000_0203);
        settle();
        chk("pre_reset_busy", bus.busy_vec, 32'h0000_0220);
        chk("pre_reset_full", 32'(bus.lu_ready), 32'h0);
        rst = 1'b1;
        settle();
        chk("rst_busy_clear", bus.busy_vec, 32'h0);
        chk("rst_lu_ready", 32'(bus.lu_ready), 32'h1);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_rf_wr_is_alu", 32'(bus.rf_wr), 32'h1);
        lu(1'b1, 5'd3, 32'h0000_0333);
        step();
        lu(1'b0, '0, '0);
        alu(1'b0, '0, '0);
        rst = 1'b0;
        settle();
        chk("post_reset_no_write", 32'(bus.rf_wr), 32'h0);
        chk("post_reset_ready", 32'(bus.lu_ready), 32'h1);
        step();
        settle();
        chk("post_reset_still_empty", 32'(bus.rf_wr), 32'h0);
        chk("post_reset_busy", bus.busy_vec, 32'h0);
        step();
        step();
        chk("all_writes_seen", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter AGE_MAX, default 3: consecutive cycles a blocked FIFO head may wait before a forced issue bubble.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 iss_valid  in  1  instruction presented at issue this cycle.
REQ-005 iss_long  in  1  issuing instruction targets the long-latency unit.
REQ-006 iss_rd, iss_rs1, iss_rs2  in  5 each  destination and source register indices of the issuing instruction.
REQ-007 stall  out  1  issue must hold this cycle.
REQ-008 alu_wr  in  1  ALU writeback request; this requester cannot be back-pressured.
REQ-009 alu_rd  in  5, alu_wdata  in  32  ALU writeback destination and data.
REQ-010 lu_valid  in  1, lu_ready  out  1  long-unit result handshake; transfer occurs when both are 1 at a rising edge.
REQ-011 lu_rd  in  5, lu_wdata  in  32  long-unit result destination and data.
REQ-012 rf_wr  out  1, rf_rd  out  5, rf_wdata  out  32  the register-file write port.
REQ-013 busy_vec  out  32  scoreboard: bit i set means a long result for xi is outstanding.

Function
REQ-014 Long-unit results SHALL pass through a 2-entry FIFO; there is no direct path from lu_wdata to rf_wdata.
REQ-015 lu_ready SHALL be 1 when fewer than 2 entries are held, with no dependence on lu_valid.
REQ-016 Write port priority SHALL be ALU first: when alu_wr=1, the port drives alu_rd/alu_wdata.
REQ-017 When alu_wr=0 and the FIFO is non-empty, the port SHALL drive the FIFO head; that head SHALL pop at the same rising edge.
REQ-018 When alu_wr=0 and the FIFO is empty, rf_wr SHALL be 0.
REQ-019 Minimum latency from lu handshake to rf_wr for that result SHALL be 1 cycle.
REQ-020 Write-port outputs SHALL be combinational from alu_* and FIFO state, so they are stable before the register file's falling-edge write.
REQ-021 A push and a pop in the same cycle SHALL both occur. A push when full SHALL be impossible because lu_ready=0.
REQ-022 Scoreboard set SHALL occur on iss_valid & iss_long & ~stall with iss_rd != 0, setting busy_vec[iss_rd].
REQ-023 Scoreboard clear SHALL occur when a FIFO entry is written to the register file, clearing busy_vec[head rd].
REQ-024 Clear and set of different bits in the same cycle SHALL both take effect. The same bit cannot be both cleared and set, because of REQ-026.
REQ-025 busy_vec[0] SHALL always be 0. Index 0 SHALL never cause a hazard.
REQ-026 stall SHALL be 1 when iss_valid=1 and any of busy_vec[iss_rs1], busy_vec[iss_rs2] or busy_vec[iss_rd] is 1 (RAW and WAW).
REQ-027 Age counter (2 bits minimum) behaviour:
  - increments each cycle the FIFO is non-empty and alu_wr=1;
  - resets to 0 on any pop or when the FIFO is empty;
  - saturates at AGE_MAX.
REQ-028 stall SHALL also be 1, regardless of iss_valid, while the age counter equals AGE_MAX. The resulting issue bubble frees the port in a later cycle.
REQ-029 stall SHALL be purely combinational; it has no registered delay.

Reset
REQ-030 While rst=1 the following SHALL hold:
  - FIFO empty, age counter 0, busy_vec=0;
  - lu_ready=1, stall driven only by REQ-026 on the cleared scoreboard (that is, 0);
  - rf_wr equals alu_wr.
REQ-031 Asserting rst mid-operation SHALL discard queued results and scoreboard bits immediately. No FIFO write SHALL occur after rst rises.

Verification
REQ-032 Long issue to x5, then lu result x5=0xDEADBEEF with alu_wr=0 -> busy_vec[5]=1 after issue; rf_wr=1, rf_rd=5, rf_wdata=0xDEADBEEF one cycle after the handshake; busy_vec[5]=0 afterwards.
REQ-033 x5 busy, issue with iss_rs2=5 -> stall=1 until the cycle after the x5 write; an issue with rs1=rs2=rd=0 never stalls.
REQ-034 Two lu results pushed while alu_wr=1 every cycle -> lu_ready=0 with 2 entries held; the age counter reaches 3; stall=1; once alu_wr drops, the head writes and the age counter clears.
REQ-035 Same-cycle ALU write x7=0x11 and FIFO head x9 -> port writes x7; x9 writes next cycle with alu_wr=0; busy_vec[9] clears then.
REQ-036 FIFO holding 1 entry, simultaneous pop and new push -> occupancy stays 1; results are written in arrival order.
REQ-037 rst asserted with 2 entries queued and busy_vec=0x0000_0220 -> immediately busy_vec=0, lu_ready=1, no FIFO write after release.
